// File: rtl/bus_pkg.sv
// Shared system-bus definitions: direction codes, data width and the
// responder state encoding used by the on-chip memory slave.
package bus_pkg;

   localparam int unsigned BusWidth = 32;

   typedef logic [BusWidth-1:0] bus_word_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [1:0] TURN = 2'd3;

endpackage

// File: rtl/bus_mem_slave_if.sv
// Request/completion signals of the shared system bus as seen by one responder.
// The read/write data lines are bidirectional and travel as a separate net.
interface bus_mem_slave_if;
   import bus_pkg::*;

   bus_word_t BUS_addr;
   logic      BUS_req;
   logic      BUS_RW;
   logic      BUS_ready;
   logic      busy;

   modport master (output BUS_addr, BUS_req, BUS_RW, input BUS_ready, busy);
   modport slave  (input BUS_addr, BUS_req, BUS_RW, output BUS_ready, busy);

endinterface

// File: rtl/bus_mem_array.sv
// Single-port synchronous word RAM, read-first.
module bus_mem_array #(
   parameter int unsigned MEM_BITS  = 10,
   parameter string       INIT_FILE = ""
) (
   input  logic                clk,
   input  logic                we,
   input  logic [MEM_BITS-1:0] addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata
);

   logic [31:0] mem_q [0:(1 << MEM_BITS) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory responder: decodes its address window, counts wait states and
// answers each read or write with a one-cycle BUS_ready pulse followed by a turnaround cycle.
module bus_mem_slave
   import bus_pkg::*;
#(
   parameter int unsigned MEM_BITS    = 10,
   parameter logic [31:0] BASE        = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  clr,
   bus_mem_slave_if.slave        bus,
   inout  wire  [BusWidth-1:0]   BUS_data
);

   localparam int unsigned TagLsb = MEM_BITS + 2;

   logic [1:0]          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [MEM_BITS-1:0] idx_q, idx_d;
   logic                rw_q, rw_d;
   bus_word_t           wdata_q, wdata_d;
   logic                drive_q, drive_d;
   logic                hit;
   logic                commit;
   bus_word_t           rdata;
   logic                unused_addr_lsb;

   assign hit             = bus.BUS_addr[31:TagLsb] == BASE[31:TagLsb];
   assign unused_addr_lsb = ^bus.BUS_addr[1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      drive_d = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.BUS_req && hit) begin
               idx_d   = bus.BUS_addr[TagLsb-1:2];
               rw_d    = bus.BUS_RW;
               wdata_d = BUS_data;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!bus.BUS_req) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
               commit  = (rw_q == RW_WRITE);
               drive_d = (rw_q == RW_READ);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = TURN;
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         rw_q    <= RW_READ;
         wdata_q <= '0;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
         drive_q <= drive_d;
      end
   end

   // Reset wins over a commit landing on the same edge, so the write is dropped.
   bus_mem_array #(
      .MEM_BITS  (MEM_BITS),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .we    (commit && !clr),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   assign bus.BUS_ready = (state_q == RESP);
   assign bus.busy      = (state_q != IDLE);
   assign BUS_data      = drive_q ? rdata : {BusWidth{1'bz}};

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed and randomized bench for bus_mem_slave: three responders share one data bus
// (2 wait states at base 0, 2 wait states at base 0x1000_0000, 0 wait states at base 0).
module tb_bus_mem_slave;
   import bus_pkg::*;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] addr, drv;
   logic        req, rw, oe;
   int          sel;
   wire  [31:0] bus_data;
   assign bus_data = oe ? drv : 32'hzzzz_zzzz;

   bus_mem_slave_if if_a ();
   bus_mem_slave_if if_b ();
   bus_mem_slave_if if_c ();

   assign if_a.BUS_addr = addr;
   assign if_a.BUS_RW   = rw;
   assign if_a.BUS_req  = req && (sel == 0);
   assign if_b.BUS_addr = addr;
   assign if_b.BUS_RW   = rw;
   assign if_b.BUS_req  = req && (sel == 1);
   assign if_c.BUS_addr = addr;
   assign if_c.BUS_RW   = rw;
   assign if_c.BUS_req  = req && (sel == 2);

   bus_mem_slave #(.MEM_BITS(10), .BASE(32'h0000_0000), .WAIT_CYCLES(2), .INIT_FILE(""))
      u_dut_a (.clk(clk), .clr(clr), .bus(if_a), .BUS_data(bus_data));
   bus_mem_slave #(.MEM_BITS(10), .BASE(32'h1000_0000), .WAIT_CYCLES(2), .INIT_FILE(""))
      u_dut_b (.clk(clk), .clr(clr), .bus(if_b), .BUS_data(bus_data));
   bus_mem_slave #(.MEM_BITS(10), .BASE(32'h0000_0000), .WAIT_CYCLES(0), .INIT_FILE(""))
      u_dut_c (.clk(clk), .clr(clr), .bus(if_c), .BUS_data(bus_data));

   logic ready, busy;
   always_comb begin
      ready = if_a.BUS_ready;
      busy  = if_a.busy;
      if (sel == 1) begin
         ready = if_b.BUS_ready;
         busy  = if_b.busy;
      end else if (sel == 2) begin
         ready = if_c.BUS_ready;
         busy  = if_c.busy;
      end
   end

   // Reference model: word contents per responder and the earliest edge each can accept.
   logic [31:0] mem_m [3][1024];
   bit          known [3][1024];
   int          free_at [3];
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic int wait_of(input int s);
      return (s == 2) ? 0 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int r_at);
      int          due;
      bit          seen;
      logic [31:0] got;
      due  = (((cyc + 1) > free_at[s]) ? (cyc + 1) : free_at[s]) + wait_of(s) + 1;
      sel  = s;
      addr = a;
      rw   = w;
      drv  = d;
      oe   = w;
      req  = 1'b1;
      seen = 1'b0;
      r_at = -1;
      got  = '0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (ready) begin
            seen = 1'b1;
            r_at = cyc;
            got  = bus_data;
         end
      end
      check("ready_seen", {31'b0, seen}, 32'd1);
      check("ready_cycle", 32'(r_at), 32'(due));
      if (!w) begin
         check("read_data", got, mem_m[s][a[11:2]]);
      end else if (seen) begin
         mem_m[s][a[11:2]] = d;
         known[s][a[11:2]] = 1'b1;
      end
      oe = 1'b0;
      if (!hold) req = 1'b0;
      @(posedge clk); #1;
      free_at[s] = seen ? (r_at + 3) : (cyc + 1);
      if (!hold) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          r, r1, r2;
      int          bad_r, bad_b, bad_d, nr;
      logic [31:0] lf_at [4];

      clr = 1'b1; req = 1'b0; rw = 1'b0; oe = 1'b0; drv = '0; addr = '0; sel = 0;
      for (int s = 0; s < 3; s++) free_at[s] = 0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(posedge clk); #1;

      check("rst_ready_a", {31'b0, if_a.BUS_ready}, 32'd0);
      check("rst_busy_a",  {31'b0, if_a.busy},      32'd0);
      check("rst_ready_b", {31'b0, if_b.BUS_ready}, 32'd0);
      check("rst_busy_b",  {31'b0, if_b.busy},      32'd0);
      check("rst_ready_c", {31'b0, if_c.BUS_ready}, 32'd0);
      check("rst_busy_c",  {31'b0, if_c.busy},      32'd0);
      oe = 1'b1; drv = 32'h0;
      #1 check("rst_bus_free", bus_data, 32'h0);
      oe = 1'b0;

      // Preload word 5, then a read of byte address 20 with the data lines probed every cycle.
      xfer(0, RW_WRITE, 32'd20, 32'hAB21_112A, 1'b0, r);
      sel = 0; addr = 32'd20; rw = RW_READ; req = 1'b1; oe = 1'b1; drv = 32'h0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check("t1_ready", {31'b0, ready}, (k == 4) ? 32'd1 : 32'd0);
         check("t1_busy",  {31'b0, busy},  (k <= 5) ? 32'd1 : 32'd0);
         if (k == 4) check("t1_data", bus_data, 32'hAB21_112A);
         else        check("t1_bus_free", bus_data, 32'h0);
         oe = (k != 3);
         if (k == 4) req = 1'b0;
      end
      oe = 1'b0;

      // Write then read back-to-back with the request held.
      xfer(0, RW_WRITE, 32'd24, 32'hAB21_1128, 1'b1, r1);
      xfer(0, RW_READ,  32'd24, 32'h0,         1'b0, r2);
      check("b2b_gap", 32'(r2 - r1), 32'd6);

      // Out-of-window requests against the responder based at 0x1000_0000.
      sel = 1; rw = RW_READ; req = 1'b1; oe = 1'b1; drv = 32'h0;
      bad_r = 0; bad_b = 0; bad_d = 0;
      for (int k = 0; k < 20; k++) begin
         addr = (k % 2 == 0) ? 32'h0000_0004 : 32'h1000_1000;
         @(posedge clk); #1;
         if (ready) bad_r++;
         if (busy) bad_b++;
         if (bus_data !== 32'h0) bad_d++;
      end
      check("oow_ready", 32'(bad_r), 32'd0);
      check("oow_busy",  32'(bad_b), 32'd0);
      check("oow_bus",   32'(bad_d), 32'd0);
      req = 1'b0; oe = 1'b0;
      @(posedge clk); #1;
      xfer(1, RW_WRITE, 32'h1000_0040, $urandom, 1'b0, r);
      xfer(1, RW_READ,  32'h1000_0040, 32'h0,    1'b0, r);

      // Abort on the very cycle the write would have committed.
      xfer(0, RW_WRITE, 32'd8, 32'h1111_0008, 1'b0, r);
      sel = 0; addr = 32'd8; rw = RW_WRITE; drv = 32'hDEAD_BEEF; oe = 1'b1; req = 1'b1;
      nr = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ready) nr++;
      end
      req = 1'b0; oe = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      repeat (4) begin
         if (ready) nr++;
         @(posedge clk); #1;
      end
      check("abort_no_ready", 32'(nr), 32'd0);
      xfer(0, RW_READ, 32'd8, 32'h0, 1'b0, r);

      // Reset asserted in WAIT of a write, again on the commit cycle.
      xfer(0, RW_WRITE, 32'd16, 32'h2222_0010, 1'b0, r);
      sel = 0; addr = 32'd16; rw = RW_WRITE; drv = 32'hBADC_0FFE; oe = 1'b1; req = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; req = 1'b0; oe = 1'b0;
      check("clr_busy",  {31'b0, busy},  32'd0);
      check("clr_ready", {31'b0, ready}, 32'd0);
      @(posedge clk); #1;
      xfer(0, RW_READ, 32'd16, 32'h0, 1'b0, r);

      // Zero-wait line fill of words 0..3.
      for (int k = 0; k < 4; k++) xfer(2, RW_WRITE, 32'(k * 4), $urandom, k != 3, r);
      for (int k = 0; k < 4; k++) begin
         xfer(2, RW_READ, 32'(k * 4), 32'h0, k != 3, r);
         lf_at[k] = 32'(r);
      end
      for (int k = 1; k < 4; k++) check("fill_gap", lf_at[k] - lf_at[k-1], 32'd4);

      // Random mix on the two base-0 responders; address bits [1:0] are noise.
      for (int i = 0; i < 40; i++) begin
         int          s;
         bit          w, h;
         logic [31:0] a;
         s = ($urandom_range(0, 1) == 0) ? 0 : 2;
         a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
         w = 1'($urandom_range(0, 1));
         if (!known[s][a[11:2]]) w = 1'b1;
         h = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
         xfer(s, w, a, $urandom, h, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
